// File: rtl/chip8_pkg.sv
// Shared CHIP-8 core definitions: sequencer state encoding, reset/stack
// addresses and the 6-bit decoded opcode identifiers used by execute.
package chip8_pkg;

    localparam int unsigned SEQ_ADDR_W  = 12;
    localparam int unsigned SEQ_TIMEOUT = 255;

    // Word address of byte 0x200, where CHIP-8 programs are loaded.
    localparam logic [15:0] PC_RESET     = 16'h0100;
    localparam logic [15:0] STACK_OFFSET = 16'h0EA0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_MEM     = 3'd2,
        ST_DECODE  = 3'd3,
        ST_EXEC    = 3'd4,
        ST_WAIT_EX = 3'd5,
        ST_UPDATE  = 3'd6,
        ST_FAULT   = 3'd7
    } seq_state_e;

    localparam logic [5:0] OP_NOP     = 6'd0;
    localparam logic [5:0] OP_CLS     = 6'd1;
    localparam logic [5:0] OP_RET     = 6'd2;
    localparam logic [5:0] OP_JP      = 6'd3;
    localparam logic [5:0] OP_CALL    = 6'd4;
    localparam logic [5:0] OP_SE_VX_B = 6'd5;
    localparam logic [5:0] OP_SNE_VXB = 6'd6;
    localparam logic [5:0] OP_LD_VX_B = 6'd7;
    localparam logic [5:0] OP_ADD_VXB = 6'd8;
    localparam logic [5:0] OP_LD_I    = 6'd9;
    localparam logic [5:0] OP_DRW     = 6'd10;
    localparam logic [5:0] OP_LD_B    = 6'd11;
    localparam logic [5:0] OP_LD_IVX  = 6'd12;
    localparam logic [5:0] OP_LD_VXI  = 6'd13;
    localparam logic [5:0] OP_LD_VX_K = 6'd14;

endpackage

// File: rtl/seq_watchdog.sv
// Execute-stage watchdog: 8-bit up-counter with synchronous clear and
// count enable; expired_c flags when the count equals TIMEOUT.
// Ports: clk, rst (async high), clr, en, expired_c.
module seq_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired_c = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/cpu_sequencer.sv
// CHIP-8 instruction sequencer: owns the PC and walks each instruction
// through FETCH -> MEM -> DECODE -> EXEC [-> WAIT_EX] -> UPDATE.
// Ports: clk, rst (async high); run/step control; imem_en/imem_addr/imem_data
// BRAM port; instr/dec_valid to the decoder; ex_start/ex_multi/ex_done/
// ex_pc_en/ex_pc_wr with execute; pc, busy, fault, retired status.
module cpu_sequencer #(
    parameter int unsigned ADDR_W   = chip8_pkg::SEQ_ADDR_W,
    parameter logic [15:0] PC_RESET = chip8_pkg::PC_RESET,
    parameter int unsigned TIMEOUT  = chip8_pkg::SEQ_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic [15:0]       instr,
    output logic              dec_valid,
    output logic              ex_start,
    input  logic              ex_multi,
    input  logic              ex_done,
    input  logic              ex_pc_en,
    input  logic [15:0]       ex_pc_wr,
    output logic [15:0]       pc,
    output logic              busy,
    output logic              fault,
    output logic [15:0]       retired
);

    import chip8_pkg::*;

    seq_state_e        state, state_n;
    logic              wd_clr_c, wd_en_c, wd_expired_c;
    logic              pc_pend;
    logic [15:0]       pc_hold;
    logic [ADDR_W-1:0] pc_inc_c;

    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clr       (wd_clr_c),
        .en        (wd_en_c),
        .expired_c (wd_expired_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Next-state and watchdog control
    always_comb begin
        state_n  = state;
        wd_clr_c = 1'b0;
        wd_en_c  = 1'b0;
        case (state)
            ST_IDLE:   if (run || step) state_n = ST_FETCH;
            ST_FETCH:  state_n = ST_MEM;
            ST_MEM:    state_n = ST_DECODE;
            ST_DECODE: state_n = ST_EXEC;
            ST_EXEC: begin
                if (ex_multi) begin
                    state_n  = ST_WAIT_EX;
                    wd_clr_c = 1'b1;
                end else begin
                    state_n  = ST_UPDATE;
                end
            end
            ST_WAIT_EX: begin
                wd_en_c = 1'b1;
                // A completing ex_done wins over a simultaneous timeout.
                if (ex_done)           state_n = ST_UPDATE;
                else if (wd_expired_c) state_n = ST_FAULT;
            end
            ST_UPDATE: state_n = run ? ST_FETCH : ST_IDLE;
            ST_FAULT:  state_n = ST_FAULT;
            default:   state_n = ST_IDLE;
        endcase
    end

    // Strobes and status registered from the upcoming state so they
    // line up with the cycle spent in that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_en   <= 1'b0;
            dec_valid <= 1'b0;
            ex_start  <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            imem_en   <= (state_n == ST_FETCH);
            dec_valid <= (state_n == ST_DECODE);
            ex_start  <= (state_n == ST_EXEC);
            busy      <= (state_n != ST_IDLE) && (state_n != ST_FAULT);
            fault     <= (state_n == ST_FAULT);
        end
    end

    assign pc_inc_c  = pc[ADDR_W-1:0] + ADDR_W'(1);
    assign imem_addr = pc[ADDR_W-1:0];

    // Opcode latch, PC capture/update and retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= PC_RESET;
            instr   <= '0;
            pc_pend <= 1'b0;
            pc_hold <= '0;
            retired <= '0;
        end else begin
            if (state == ST_MEM) instr <= imem_data;

            if ((state == ST_EXEC || state == ST_WAIT_EX) && ex_pc_en) begin
                pc_pend <= 1'b1;
                pc_hold <= ex_pc_wr;
            end

            if (state == ST_UPDATE) begin
                pc      <= pc_pend ? pc_hold : 16'(pc_inc_c);
                pc_pend <= 1'b0;
                retired <= retired + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a registered BRAM model and a
// hand-driven execute stage; expected values are hand-computed.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, step;
    logic        imem_en;
    logic [11:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic        dec_valid, ex_start;
    logic        ex_multi, ex_done, ex_pc_en;
    logic [15:0] ex_pc_wr;
    logic [15:0] pc;
    logic        busy, fault;
    logic [15:0] retired;

    logic [15:0] mem [0:4095];

    int n_vec   = 0;
    int n_err   = 0;
    int n_start = 0;
    int n_imem  = 0;

    cpu_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .step      (step),
        .imem_en   (imem_en),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .instr     (instr),
        .dec_valid (dec_valid),
        .ex_start  (ex_start),
        .ex_multi  (ex_multi),
        .ex_done   (ex_done),
        .ex_pc_en  (ex_pc_en),
        .ex_pc_wr  (ex_pc_wr),
        .pc        (pc),
        .busy      (busy),
        .fault     (fault),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    // Registered-read instruction BRAM
    always @(posedge clk) begin
        if (imem_en) imem_data <= mem[imem_addr];
    end

    always @(negedge clk) begin
        if (ex_start === 1'b1) n_start++;
        if (imem_en === 1'b1)  n_imem++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ex_start();
        int k = 0;
        while (ex_start !== 1'b1 && k < 12) begin
            tick();
            k++;
        end
        check("ex_start_seen", 32'(ex_start), 32'd1);
    endtask

    // One single-cycle instruction in step mode, optionally writing the PC.
    task automatic step_instr(input logic jmp, input logic [15:0] tgt);
        ex_multi = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_ex_start();
        if (jmp) begin
            ex_pc_en = 1'b1;
            ex_pc_wr = tgt;
        end
        tick();
        ex_pc_en = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        int base;
        rst = 1'b1; run = 1'b0; step = 1'b0;
        ex_multi = 1'b0; ex_done = 1'b0; ex_pc_en = 1'b0; ex_pc_wr = '0;
        imem_data = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h100] = 16'h6A05;
        mem[12'h101] = 16'h1123;
        mem[12'h123] = 16'hD015;

        repeat (3) tick();
        check("rst_pc",        32'(pc),        32'h0100);
        check("rst_retired",   32'(retired),   32'd0);
        check("rst_instr",     32'(instr),     32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_fault",     32'(fault),     32'd0);
        check("rst_imem_en",   32'(imem_en),   32'd0);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_ex_start",  32'(ex_start),  32'd0);

        // Free-run: LD VA,5 then JMP 0x123
        rst = 1'b0; run = 1'b1;
        tick();
        check("c1_imem_en",   32'(imem_en),   32'd1);
        check("c1_imem_addr", 32'(imem_addr), 32'h100);
        check("c1_busy",      32'(busy),      32'd1);
        tick();
        check("c2_imem_en",   32'(imem_en),   32'd0);
        tick();
        check("c3_dec_valid", 32'(dec_valid), 32'd1);
        check("c3_instr",     32'(instr),     32'h6A05);
        tick();
        check("c4_ex_start",  32'(ex_start),  32'd1);
        check("c4_dec_valid", 32'(dec_valid), 32'd0);
        tick();
        check("c5_pc_stable", 32'(pc),        32'h0100);
        tick();
        check("c6_pc",        32'(pc),        32'h0101);
        check("c6_retired",   32'(retired),   32'd1);
        check("c6_imem_addr", 32'(imem_addr), 32'h101);
        tick(); tick(); tick();
        check("jmp_ex_start", 32'(ex_start),  32'd1);
        check("jmp_instr",    32'(instr),     32'h1123);
        ex_pc_en = 1'b1; ex_pc_wr = 16'h0123;
        tick();
        ex_pc_en = 1'b0;
        check("jmp_pc_hold",  32'(pc),        32'h0101);
        tick();
        check("jmp_pc",        32'(pc),        32'h0123);
        check("jmp_imem_addr", 32'(imem_addr), 32'h123);
        check("jmp_imem_en",   32'(imem_en),   32'd1);

        // Multi-cycle op, ex_done 7 cycles after ex_start; run drops mid-op
        ex_multi = 1'b1; run = 1'b0;
        tick(); tick(); tick();
        check("multi_ex_start", 32'(ex_start), 32'd1);
        for (int c = 5; c <= 11; c++) begin
            tick();
            check("multi_busy", 32'(busy), 32'd1);
        end
        ex_done = 1'b1;
        tick();
        ex_done = 1'b0;
        check("multi_upd_busy", 32'(busy), 32'd1);
        check("multi_upd_pc",   32'(pc),   32'h0123);
        tick();
        check("multi_pc",      32'(pc),      32'h0124);
        check("multi_idle",    32'(busy),    32'd0);
        check("multi_retired", 32'(retired), 32'd3);
        ex_multi = 1'b0;

        // ex_done / ex_pc_en while idle must be ignored
        ex_done = 1'b1; ex_pc_en = 1'b1; ex_pc_wr = 16'h0777;
        tick(); tick();
        ex_done = 1'b0; ex_pc_en = 1'b0;
        check("idle_ign_pc",   32'(pc),   32'h0124);
        check("idle_ign_busy", 32'(busy), 32'd0);

        // Step mode: two steps ~20 cycles apart
        base = n_start;
        step_instr(1'b0, 16'h0000);
        repeat (15) tick();
        step_instr(1'b0, 16'h0000);
        repeat (15) tick();
        check("step_count",   32'(n_start - base), 32'd2);
        check("step_retired", 32'(retired),        32'd5);
        check("step_pc",      32'(pc),             32'h0126);

        // step together with run: only the run-started instruction executes
        run = 1'b1; step = 1'b1;
        tick();
        run = 1'b0; step = 1'b0;
        repeat (20) tick();
        check("steprun_retired", 32'(retired), 32'd6);
        check("steprun_pc",      32'(pc),      32'h0127);
        check("steprun_busy",    32'(busy),    32'd0);

        // PC wrap at the top of instruction memory
        step_instr(1'b1, 16'h0FFF);
        check("wrap_jmp_pc", 32'(pc), 32'h0FFF);
        step_instr(1'b0, 16'h0000);
        check("wrap_pc",      32'(pc),      32'h0000);
        check("wrap_retired", 32'(retired), 32'd8);

        // Reset in WAIT_EX with a pending PC write
        ex_multi = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_ex_start();
        tick();
        ex_pc_en = 1'b1; ex_pc_wr = 16'h0456;
        tick();
        ex_pc_en = 1'b0;
        tick();
        check("wait_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_pc",      32'(pc),      32'h0100);
        check("arst_busy",    32'(busy),    32'd0);
        check("arst_fault",   32'(fault),   32'd0);
        check("arst_retired", 32'(retired), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        step_instr(1'b0, 16'h0000);
        check("post_rst_pc", 32'(pc), 32'h0101);

        // Watchdog timeout
        ex_multi = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_ex_start();
        n = 0;
        while (fault !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check("to_cycles", 32'(n),     32'd257);
        check("to_fault",  32'(fault), 32'd1);
        check("to_busy",   32'(busy),  32'd0);
        base = n_imem;
        ex_done = 1'b1; run = 1'b1;
        tick();
        ex_done = 1'b0;
        repeat (20) tick();
        run = 1'b0;
        check("to_no_fetch", 32'(n_imem - base), 32'd0);
        check("to_sticky",   32'(fault),         32'd1);
        check("to_pc",       32'(pc),            32'h0101);
        check("to_retired",  32'(retired),       32'd1);

        rst = 1'b1;
        #1;
        check("clr_fault", 32'(fault), 32'd0);
        check("clr_pc",    32'(pc),    32'h0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
